// File: rtl/lsu_ctrl.sv
// Load/store unit in front of a word-organised data memory.
// Sub-word loads are extracted/extended; sub-word stores do read-modify-write.
module lsu_ctrl #(
   parameter int WADDR_W = 6,
   parameter int XLEN    = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_we,
   input  logic [2:0]         req_funct3,
   input  logic [31:0]        req_addr,
   input  logic [XLEN-1:0]    req_wdata,
   output logic               resp_valid,
   output logic [XLEN-1:0]    resp_rdata,
   output logic               resp_err,
   output logic               mem_read,
   output logic               mem_write,
   output logic [WADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]    mem_wdata,
   input  logic [XLEN-1:0]    mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_RMW,
      S_WR,
      S_RESP
   } state_t;

   state_t state_q, state_d;

   logic [WADDR_W+1:0] addr_q;
   logic [2:0]         f3_q;
   logic [XLEN-1:0]    wdata_q;
   logic [XLEN-1:0]    buf_q;
   logic [XLEN-1:0]    rdata_q;
   logic               err_q;

   logic            accept;
   logic            illegal;
   logic            misal;
   logic            req_err;
   logic [7:0]      lane_b;
   logic [15:0]     lane_h;
   logic [XLEN-1:0] load_ext;
   logic [XLEN-1:0] merged;
   logic            unused_addr;

   // Address bits above the memory window are ignored so addresses wrap.
   assign unused_addr = ^req_addr[31:WADDR_W+2];

   assign accept = req_valid & req_ready;

   assign illegal = (req_funct3 == 3'b011)
                  | (req_funct3[2:1] == 2'b11)
                  | (req_we & req_funct3[2]);

   assign misal = ((req_funct3[1:0] == 2'b01) & req_addr[0])
                | ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));

   assign req_err = illegal | misal;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (req_err) begin
                  state_d = S_RESP;
               end else if (!req_we) begin
                  state_d = S_RD;
               end else if (req_funct3[1:0] == 2'b10) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RMW;
               end
            end
         end
         S_RD:    state_d = S_RESP;
         S_RMW:   state_d = S_WR;
         S_WR:    state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
         3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
         3'b100:  load_ext = {24'd0, lane_b};
         3'b101:  load_ext = {16'd0, lane_h};
         default: load_ext = mem_rdata;
      endcase
   end

   // Only the addressed lane is replaced; the rest keep the value just read.
   always_comb begin
      merged = mem_rdata;
      if (f3_q[0]) begin
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end else begin
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         f3_q    <= '0;
         wdata_q <= '0;
         buf_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= req_addr[WADDR_W+1:0];
            f3_q    <= req_funct3;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= req_err;
         end
         if (state_q == S_RD) begin
            rdata_q <= load_ext;
         end
         if (state_q == S_RMW) begin
            buf_q <= merged;
         end
      end
   end

   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state_q)
         S_IDLE: req_ready = 1'b1;
         S_RD, S_RMW: begin
            mem_read = 1'b1;
            mem_addr = addr_q[WADDR_W+1:2];
         end
         S_WR: begin
            mem_write = 1'b1;
            mem_addr  = addr_q[WADDR_W+1:2];
            mem_wdata = (f3_q[1:0] == 2'b10) ? wdata_q : buf_q;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = rdata_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, corner sequences and
// random traffic against a word-array reference model.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] dmem [64];
   bit   [31:0] ref_mem [64];

   int total = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lsu_ctrl #(.WADDR_W(6), .XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   assign mem_rdata = mem_read ? dmem[mem_addr] : 32'h0;

   always @(posedge clk) begin
      if (mem_write) dmem[mem_addr] <= mem_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: what one request does to a plain array of words.
   function automatic void ref_op(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr,
                                  input logic [31:0] wd,
                                  output logic err,
                                  output logic [31:0] rd,
                                  output int lat);
      int idx;
      int sh;
      bit [31:0] word;
      bit [31:0] mask;
      bit [31:0] v;
      bit bad_f3;
      bit bad_al;
      idx = (addr / 4) % 64;
      word = ref_mem[idx];
      bad_f3 = (f3 == 3) || (f3 == 6) || (f3 == 7) ||
               (we && (f3 == 4 || f3 == 5));
      bad_al = ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) ||
               ((f3 == 2) && (addr % 4 != 0));
      rd = 0;
      err = 0;
      if (bad_f3 || bad_al) begin
         err = 1;
         lat = 1;
         return;
      end
      if (f3 == 0 || f3 == 4) begin
         sh = 8 * (addr % 4);
         mask = 32'hFF;
      end else if (f3 == 1 || f3 == 5) begin
         sh = 16 * ((addr / 2) % 2);
         mask = 32'hFFFF;
      end else begin
         sh = 0;
         mask = 32'hFFFF_FFFF;
      end
      if (!we) begin
         lat = 2;
         v = (word >> sh) & mask;
         if (f3 == 0 && v >= 128) v = v - 256;
         if (f3 == 1 && v >= 32768) v = v - 65536;
         rd = v;
      end else begin
         lat = (f3 == 2) ? 2 : 3;
         ref_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
      end
   endfunction

   task automatic accept_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr,
                             input logic [31:0] wd, output bit acc);
      req_valid = 1'b1;
      req_we = we;
      req_funct3 = f3;
      req_addr = addr;
      req_wdata = wd;
      acc = 0;
      for (int i = 0; i < 10 && !acc; i++) begin
         acc = req_ready;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      req_we = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr = $urandom;
      req_wdata = $urandom;
      if (!acc) begin
         total++;
         fails++;
         $display("FAIL accept: got no accept expected accept");
      end
   endtask

   task automatic run_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic err, output logic [31:0] rd,
                          output int lat, output int nacc,
                          output int both, output int wcyc,
                          output logic [31:0] wdat,
                          output logic [5:0] wad);
      bit acc;
      err = 0; rd = 0; lat = -1; nacc = 0; both = 0;
      wcyc = 0; wdat = 0; wad = 0;
      accept_req(we, f3, addr, wd, acc);
      if (!acc) return;
      for (int k = 1; k <= 8; k++) begin
         if (mem_read || mem_write) nacc++;
         if (mem_read && mem_write) both++;
         if (mem_write && wcyc == 0) begin
            wcyc = k;
            wdat = mem_wdata;
            wad = mem_addr;
         end
         if (resp_valid) begin
            lat = k;
            err = resp_err;
            rd = resp_rdata;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        err;
      logic [31:0] rd;
      int          lat;
      int          wcyc;
      logic [31:0] word;
   } vec_t;

   vec_t tv[15];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        e, me;
      logic [31:0] r, mr, wdat;
      logic [5:0]  wad;
      int          lat, mlat, nacc, both, wcyc;
      logic [31:0] exp_q[$];
      logic [31:0] got_q[$];
      int          nacc_b2b, bad_rdy, idx, iters;
      bit          rdy;
      logic [31:0] b2b_addr [3];
      logic [2:0]  b2b_f3 [3];

      tv[0]  = '{1, 3'b010, 32'h10,  32'h8070F0A5, 0, 32'h0,        2, 1, 32'h8070F0A5};
      tv[1]  = '{0, 3'b000, 32'h10,  32'h0,        0, 32'hFFFFFFA5, 2, 0, 32'h8070F0A5};
      tv[2]  = '{0, 3'b100, 32'h13,  32'h0,        0, 32'h00000080, 2, 0, 32'h8070F0A5};
      tv[3]  = '{0, 3'b001, 32'h12,  32'h0,        0, 32'hFFFF8070, 2, 0, 32'h8070F0A5};
      tv[4]  = '{0, 3'b101, 32'h10,  32'h0,        0, 32'h0000F0A5, 2, 0, 32'h8070F0A5};
      tv[5]  = '{0, 3'b010, 32'h10,  32'h0,        0, 32'h8070F0A5, 2, 0, 32'h8070F0A5};
      tv[6]  = '{1, 3'b000, 32'h11,  32'hDEADBE55, 0, 32'h0,        3, 2, 32'h807055A5};
      tv[7]  = '{0, 3'b010, 32'h10,  32'h0,        0, 32'h807055A5, 2, 0, 32'h807055A5};
      tv[8]  = '{1, 3'b001, 32'h12,  32'h00001234, 0, 32'h0,        3, 2, 32'h123455A5};
      tv[9]  = '{0, 3'b010, 32'h12,  32'h0,        1, 32'h0,        1, 0, 32'h123455A5};
      tv[10] = '{1, 3'b001, 32'h13,  32'h0000BEEF, 1, 32'h0,        1, 0, 32'h123455A5};
      tv[11] = '{0, 3'b011, 32'h10,  32'h0,        1, 32'h0,        1, 0, 32'h123455A5};
      tv[12] = '{1, 3'b100, 32'h10,  32'h000000AA, 1, 32'h0,        1, 0, 32'h123455A5};
      tv[13] = '{0, 3'b010, 32'h110, 32'h0,        0, 32'h123455A5, 2, 0, 32'h123455A5};
      tv[14] = '{0, 3'b000, 32'h13,  32'h0,        0, 32'h00000012, 2, 0, 32'h123455A5};

      rst = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_funct3 = 3'b0;
      req_addr = 32'h0;
      req_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      rst = 1'b0;

      // Fill memory with known words through the unit itself.
      for (int i = 0; i < 64; i++) begin
         logic [31:0] d;
         d = 32'h5A000000 ^ (32'(i) * 32'h01030507);
         ref_op(1, 3'b010, 32'(i * 4), d, me, mr, mlat);
         run_req(1, 3'b010, 32'(i * 4), d, e, r, lat, nacc, both, wcyc,
                 wdat, wad);
      end
      chk("preload_word7", dmem[7], ref_mem[7]);

      for (int i = 0; i < 15; i++) begin
         ref_op(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wd, me, mr, mlat);
         run_req(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wd,
                 e, r, lat, nacc, both, wcyc, wdat, wad);
         chk($sformatf("tv%0d_err", i), 32'(e), 32'(tv[i].err));
         chk($sformatf("tv%0d_rdata", i), r, tv[i].rd);
         chk($sformatf("tv%0d_lat", i), lat, tv[i].lat);
         chk($sformatf("tv%0d_wcyc", i), wcyc, tv[i].wcyc);
         chk($sformatf("tv%0d_word", i), dmem[4], tv[i].word);
         chk($sformatf("tv%0d_both", i), both, 0);
         if (tv[i].err) chk($sformatf("tv%0d_noacc", i), nacc, 0);
         if (tv[i].wcyc != 0) chk($sformatf("tv%0d_waddr", i), 32'(wad), 32'd4);
         if (i == 0) chk("sw_wdata", wdat, 32'h8070F0A5);
         if (i == 6) chk("sb_wdata", wdat, 32'h807055A5);
      end

      // Reset in the middle of a sub-word store's read cycle.
      begin
         bit acc;
         accept_req(1, 3'b000, 32'h11, 32'h00000077, acc);
         chk("rmw_read", 32'(mem_read), 32'd1);
         rst = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
         chk("rstmid_mem_write", 32'(mem_write), 32'd0);
         chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
         chk("rstmid_req_ready", 32'(req_ready), 32'd1);
         @(posedge clk);
         #1;
         chk("rstmid_resp_valid2", 32'(resp_valid), 32'd0);
         chk("rstmid_word", dmem[4], 32'h123455A5);
      end

      // Three loads offered back-to-back with req_valid held high.
      b2b_addr[0] = 32'h10;  b2b_f3[0] = 3'b010;
      b2b_addr[1] = 32'h13;  b2b_f3[1] = 3'b000;
      b2b_addr[2] = 32'h22;  b2b_f3[2] = 3'b101;
      for (int i = 0; i < 3; i++) begin
         ref_op(0, b2b_f3[i], b2b_addr[i], 32'h0, me, mr, mlat);
         exp_q.push_back(mr);
      end
      idx = 0;
      bad_rdy = 0;
      nacc_b2b = 0;
      iters = 0;
      req_valid = 1'b1;
      req_we = 1'b0;
      req_funct3 = b2b_f3[0];
      req_addr = b2b_addr[0];
      req_wdata = 32'h0;
      for (int c = 1; c <= 20; c++) begin
         rdy = req_ready;
         @(posedge clk);
         #1;
         if (rdy && req_valid) begin
            nacc_b2b++;
            idx++;
            if (idx < 3) begin
               req_funct3 = b2b_f3[idx];
               req_addr = b2b_addr[idx];
            end else begin
               req_valid = 1'b0;
            end
         end
         if ((mem_read || resp_valid) && req_ready) bad_rdy++;
         if (resp_valid) got_q.push_back(resp_rdata);
         if (got_q.size() == 3) begin
            iters = c;
            break;
         end
      end
      chk("b2b_accepts", nacc_b2b, 3);
      chk("b2b_ready_low", bad_rdy, 0);
      chk("b2b_cycles", iters, 8);
      chk("b2b_nresp", got_q.size(), 3);
      for (int i = 0; i < 3 && i < got_q.size(); i++)
         chk($sformatf("b2b_rdata%0d", i), got_q[i], exp_q[i]);

      // Random traffic against the reference.
      for (int n = 0; n < 250; n++) begin
         logic        rwe;
         logic [2:0]  rf3;
         logic [31:0] ra, rwd;
         int          widx;
         rwe = 1'($urandom);
         rf3 = 3'($urandom_range(0, 7));
         ra = $urandom_range(0, 1023);
         rwd = $urandom;
         widx = (ra / 4) % 64;
         ref_op(rwe, rf3, ra, rwd, me, mr, mlat);
         run_req(rwe, rf3, ra, rwd, e, r, lat, nacc, both, wcyc, wdat, wad);
         chk($sformatf("rnd%0d_err", n), 32'(e), 32'(me));
         chk($sformatf("rnd%0d_rdata", n), r, mr);
         chk($sformatf("rnd%0d_lat", n), lat, mlat);
         chk($sformatf("rnd%0d_word", n), dmem[widx], ref_mem[widx]);
         chk($sformatf("rnd%0d_both", n), both, 0);
         if (me) chk($sformatf("rnd%0d_noacc", n), nacc, 0);
      end

      for (int i = 0; i < 64; i++)
         chk($sformatf("final_mem%0d", i), dmem[i], ref_mem[i]);

      $display("test done: total=%0d bad=%0d", total, fails);
      $finish;
   end

endmodule
